memory_access_stage: RTL and testbench

//   Memory-access pipeline stage. Sits directly upstream of WriteBack and feeds its writeBackControl, readData and result inputs.

---
 rtl/memory_access_stage_if.sv | 31 +++
 rtl/memory_access_stage.sv | 160 ++++++++++++++++
 tb/tb_memory_access_stage.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_access_stage_if.sv
// Data-memory request/acknowledge bus between the memory-access stage (master)
// and the data memory (slave).
interface memory_access_stage_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  memReq;
   logic                  memWrite;
   logic [ADDR_WIDTH-1:0] memAddr;
   logic [DATA_WIDTH-1:0] memWriteData;
   logic                  memAck;
   logic [DATA_WIDTH-1:0] memReadData;

   modport master (
      output memReq,
      output memWrite,
      output memAddr,
      output memWriteData,
      input  memAck,
      input  memReadData
   );

   modport slave (
      input  memReq,
      input  memWrite,
      input  memAddr,
      input  memWriteData,
      output memAck,
      output memReadData
   );
endinterface

// File: rtl/memory_access_stage.sv
// Memory-access pipeline stage feeding WriteBack: runs loads/stores on a req/ack bus.
// Optional ack timeout is enabled by defining MEM_TIMEOUT_EN.
module memory_access_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_inValid,
   input  logic [1:0]            i_memControl,
   input  logic [1:0]            i_writeBackControlIn,
   input  logic [DATA_WIDTH-1:0] i_resultIn,
   input  logic [DATA_WIDTH-1:0] i_storeData,
   output logic                  o_stall,
   memory_access_stage_if.master mem_bus,
   output logic                  o_outValid,
   output logic [1:0]            o_writeBackControl,
   output logic [DATA_WIDTH-1:0] o_readData,
   output logic [DATA_WIDTH-1:0] o_result,
   output logic                  o_memError
);
   localparam logic [1:0] MC_LOAD  = 2'b01;
   localparam logic [1:0] MC_STORE = 2'b10;

   typedef enum logic {
      ST_IDLE,
      ST_WAIT
   } state_t;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must lie in 1..255");
   end

   state_t                r_state;
   logic                  r_mem_req;
   logic                  r_mem_write;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_wdata;
   logic [1:0]            r_wbc_cap;
   logic [DATA_WIDTH-1:0] r_result_cap;
   logic                  r_out_valid;
   logic [1:0]            r_wbc;
   logic [DATA_WIDTH-1:0] r_read_data;
   logic [DATA_WIDTH-1:0] r_result;

   logic                  w_is_mem;
   logic                  w_is_store;
   logic                  w_timeout;
   logic [ADDR_WIDTH-1:0] w_addr;

   assign w_is_store = (i_memControl == MC_STORE);
   assign w_is_mem   = (i_memControl == MC_LOAD) || w_is_store;

   // The address is the low part of the ALU result, zero-extended if the bus is wider.
   if (ADDR_WIDTH <= DATA_WIDTH) begin : g_addr_trunc
      assign w_addr = i_resultIn[ADDR_WIDTH-1:0];
   end else begin : g_addr_ext
      assign w_addr = {{(ADDR_WIDTH-DATA_WIDTH){1'b0}}, i_resultIn};
   end

   // Gated by reset so the upstream is released the instant reset asserts.
   assign o_stall = ~reset & (((r_state == ST_IDLE) & i_inValid & w_is_mem) |
                              (r_state == ST_WAIT));

`ifdef MEM_TIMEOUT_EN
   logic [7:0] r_wait_cnt;
   logic       r_mem_error;

   // Fires on the edge that ends the TIMEOUT_CYCLES-th WAIT cycle; a same-edge ack has priority.
   assign w_timeout = (r_state == ST_WAIT) && !mem_bus.memAck &&
                      (r_wait_cnt == 8'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wait_cnt  <= '0;
         r_mem_error <= 1'b0;
      end else begin
         r_mem_error <= w_timeout;
         if (r_state != ST_WAIT) begin
            r_wait_cnt <= '0;
         end else if (!mem_bus.memAck) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
         end
      end
   end

   assign o_memError = r_mem_error;
`else
   assign w_timeout  = 1'b0;
   assign o_memError = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_mem_req    <= 1'b0;
         r_mem_write  <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_wbc_cap    <= '0;
         r_result_cap <= '0;
         r_out_valid  <= 1'b0;
         r_wbc        <= '0;
         r_read_data  <= '0;
         r_result     <= '0;
      end else begin
         r_out_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_inValid) begin
                  if (w_is_mem) begin
                     r_mem_req    <= 1'b1;
                     r_mem_write  <= w_is_store;
                     r_mem_addr   <= w_addr;
                     r_mem_wdata  <= i_storeData;
                     r_wbc_cap    <= i_writeBackControlIn;
                     r_result_cap <= i_resultIn;
                     r_state      <= ST_WAIT;
                  end else begin
                     r_out_valid <= 1'b1;
                     r_wbc       <= i_writeBackControlIn;
                     r_result    <= i_resultIn;
                     r_read_data <= '0;
                  end
               end
            end
            ST_WAIT: begin
               if (mem_bus.memAck) begin
                  r_mem_req   <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_wbc       <= r_wbc_cap;
                  r_result    <= r_result_cap;
                  r_read_data <= r_mem_write ? '0 : mem_bus.memReadData;
                  r_state     <= ST_IDLE;
               end else if (w_timeout) begin
                  // Abandoned op: retire it with no write-back so the pipeline keeps moving.
                  r_mem_req   <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_wbc       <= 2'b00;
                  r_result    <= r_result_cap;
                  r_read_data <= '0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign mem_bus.memReq       = r_mem_req;
   assign mem_bus.memWrite     = r_mem_write;
   assign mem_bus.memAddr      = r_mem_addr;
   assign mem_bus.memWriteData = r_mem_wdata;

   assign o_outValid         = r_out_valid;
   assign o_writeBackControl = r_wbc;
   assign o_readData         = r_read_data;
   assign o_result           = r_result;
endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: vector table, directed multi-cycle sequences and a
// randomized run against a transaction-level reference model.
module tb_memory_access_stage;
   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          inValid;
   logic [1:0]    memControl;
   logic [1:0]    wbcIn;
   logic [DW-1:0] resultIn;
   logic [DW-1:0] storeData;
   logic          stall;
   logic          outValid;
   logic [1:0]    wbc;
   logic [DW-1:0] readData;
   logic [DW-1:0] result;
   logic          memError;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   memory_access_stage_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

   memory_access_stage #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .i_inValid           (inValid),
      .i_memControl        (memControl),
      .i_writeBackControlIn(wbcIn),
      .i_resultIn          (resultIn),
      .i_storeData         (storeData),
      .o_stall             (stall),
      .mem_bus             (bus),
      .o_outValid          (outValid),
      .o_writeBackControl  (wbc),
      .o_readData          (readData),
      .o_result            (result),
      .o_memError          (memError)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Move to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] mc, input logic [1:0] wb,
                        input logic [DW-1:0] res, input logic [DW-1:0] sd);
      inValid    = v;
      memControl = mc;
      wbcIn      = wb;
      resultIn   = res;
      storeData  = sd;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, 2'b00, 2'b00, '0, '0);
      bus.memAck      = 1'b0;
      bus.memReadData = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   typedef struct {
      logic          v;
      logic [1:0]    mc;
      logic [1:0]    wb;
      logic [DW-1:0] res;
      logic          exp_ov;
      logic [1:0]    exp_wbc;
      logic [DW-1:0] exp_res;
   } vec_t;

   typedef struct {
      logic [1:0]    mc;
      logic [1:0]    wb;
      logic [DW-1:0] res;
      logic [DW-1:0] sd;
   } instr_t;

   vec_t tbl[6];

   initial begin
      // Non-memory ops and idle cycles; held values follow from the previous row.
      tbl[0] = '{1'b1, 2'b00, 2'd2, 32'd200,        1'b1, 2'd2, 32'd200};
      tbl[1] = '{1'b1, 2'b11, 2'd3, 32'h0000_1234,  1'b1, 2'd3, 32'h0000_1234};
      tbl[2] = '{1'b0, 2'b00, 2'd1, 32'h0000_5555,  1'b0, 2'd3, 32'h0000_1234};
      tbl[3] = '{1'b1, 2'b00, 2'd0, 32'hFFFF_FFFF,  1'b1, 2'd0, 32'hFFFF_FFFF};
      tbl[4] = '{1'b0, 2'b01, 2'd2, 32'd7,          1'b0, 2'd0, 32'hFFFF_FFFF};
      tbl[5] = '{1'b1, 2'b11, 2'd1, 32'd0,          1'b1, 2'd1, 32'd0};

      // ---------------- reset state ----------------
      do_reset();
      chk("rst_outValid", outValid, 0);
      chk("rst_memReq", bus.memReq, 0);
      chk("rst_result", result, 0);
      chk("rst_readData", readData, 0);
      chk("rst_wbc", wbc, 0);
      chk("rst_memError", memError, 0);
      chk("rst_stall", stall, 0);

      // ---------------- vector table ----------------
      for (int i = 0; i < 6; i++) begin
         drive(tbl[i].v, tbl[i].mc, tbl[i].wb, tbl[i].res, 32'hABCD_0000);
         #1;
         chk($sformatf("tbl%0d_stall", i), stall, 0);
         tick();
         chk($sformatf("tbl%0d_outValid", i), outValid, tbl[i].exp_ov);
         chk($sformatf("tbl%0d_wbc", i), wbc, tbl[i].exp_wbc);
         chk($sformatf("tbl%0d_result", i), result, tbl[i].exp_res);
         chk($sformatf("tbl%0d_readData", i), readData, 0);
         chk($sformatf("tbl%0d_memReq", i), bus.memReq, 0);
      end
      drive(1'b0, 2'b00, 2'b00, '0, '0);
      tick();

      // ---------------- load, ack 3 cycles after memReq ----------------
      drive(1'b1, 2'b01, 2'd1, 32'h40, 32'h1111);
      #1;
      chk("ld_accept_stall", stall, 1);
      tick();
      drive(1'b0, 2'b00, 2'b00, '0, '0);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("ld_w%0d_memReq", i), bus.memReq, 1);
         chk($sformatf("ld_w%0d_memAddr", i), bus.memAddr, 32'h40);
         chk($sformatf("ld_w%0d_memWrite", i), bus.memWrite, 0);
         chk($sformatf("ld_w%0d_stall", i), stall, 1);
         chk($sformatf("ld_w%0d_outValid", i), outValid, 0);
         tick();
      end
      bus.memAck      = 1'b1;
      bus.memReadData = 32'd100;
      #1;
      chk("ld_ack_stall", stall, 1);
      chk("ld_ack_memReq", bus.memReq, 1);
      tick();
      bus.memAck = 1'b0;
      chk("ld_done_outValid", outValid, 1);
      chk("ld_done_readData", readData, 100);
      chk("ld_done_result", result, 32'h40);
      chk("ld_done_wbc", wbc, 1);
      chk("ld_done_memReq", bus.memReq, 0);
      chk("ld_done_memError", memError, 0);
      #1;
      chk("ld_done_stall", stall, 0);
      tick();
      chk("ld_after_outValid", outValid, 0);

      // ---------------- store, ack in first memReq cycle ----------------
      drive(1'b1, 2'b10, 2'd0, 32'h80, 32'hDEAD);
      tick();
      drive(1'b0, 2'b00, 2'b00, '0, '0);
      chk("st_memReq", bus.memReq, 1);
      chk("st_memWrite", bus.memWrite, 1);
      chk("st_memWriteData", bus.memWriteData, 32'hDEAD);
      chk("st_memAddr", bus.memAddr, 32'h80);
      chk("st_c1_outValid", outValid, 0);
      bus.memAck      = 1'b1;
      bus.memReadData = 32'h5A5A;
      tick();
      bus.memAck = 1'b0;
      chk("st_c2_outValid", outValid, 1);
      chk("st_readData", readData, 0);
      chk("st_result", result, 32'h80);
      chk("st_memReq_off", bus.memReq, 0);

      // ---------------- load followed by held non-memory op ----------------
      drive(1'b1, 2'b01, 2'd1, 32'h10, 32'h0);
      tick();
      drive(1'b1, 2'b00, 2'd2, 32'h99, 32'h0);
      #1;
      chk("seq_c1_stall", stall, 1);
      chk("seq_c1_outValid", outValid, 0);
      tick();
      bus.memAck      = 1'b1;
      bus.memReadData = 32'h77;
      #1;
      chk("seq_c2_stall", stall, 1);
      chk("seq_c2_outValid", outValid, 0);
      tick();
      bus.memAck = 1'b0;
      chk("seq_c3_outValid", outValid, 1);
      chk("seq_c3_result", result, 32'h10);
      chk("seq_c3_readData", readData, 32'h77);
      #1;
      chk("seq_c3_stall", stall, 0);
      tick();
      drive(1'b0, 2'b00, 2'b00, '0, '0);
      chk("seq_c4_outValid", outValid, 1);
      chk("seq_c4_result", result, 32'h99);
      chk("seq_c4_wbc", wbc, 2);
      chk("seq_c4_readData", readData, 0);
      tick();
      chk("seq_c5_outValid", outValid, 0);

`ifdef MEM_TIMEOUT_EN
      // ---------------- timeout, no ack ----------------
      drive(1'b1, 2'b01, 2'd3, 32'h200, 32'h0);
      tick();
      drive(1'b0, 2'b00, 2'b00, '0, '0);
      for (int i = 0; i < TMO; i++) begin
         chk($sformatf("tmo_w%0d_memReq", i), bus.memReq, 1);
         chk($sformatf("tmo_w%0d_memError", i), memError, 0);
         tick();
      end
      chk("tmo_memError", memError, 1);
      chk("tmo_outValid", outValid, 1);
      chk("tmo_wbc", wbc, 0);
      chk("tmo_readData", readData, 0);
      chk("tmo_memReq", bus.memReq, 0);
      tick();
      chk("tmo_after_memError", memError, 0);
      chk("tmo_after_outValid", outValid, 0);
`endif

      // ---------------- async reset mid-WAIT ----------------
      drive(1'b1, 2'b01, 2'd1, 32'h300, 32'h0);
      tick();
      drive(1'b0, 2'b00, 2'b00, '0, '0);
      chk("rmid_memReq_before", bus.memReq, 1);
      reset = 1'b1;
      #1;
      chk("rmid_memReq", bus.memReq, 0);
      chk("rmid_outValid", outValid, 0);
      chk("rmid_stall", stall, 0);
      chk("rmid_result", result, 0);
      tick();
      reset = 1'b0;
      drive(1'b1, 2'b00, 2'd2, 32'h55, 32'h0);
      #1;
      chk("rmid_idle_stall", stall, 0);
      tick();
      drive(1'b0, 2'b00, 2'b00, '0, '0);
      chk("rmid_idle_outValid", outValid, 1);
      chk("rmid_idle_result", result, 32'h55);
      chk("rmid_idle_memReq", bus.memReq, 0);

      // ---------------- randomized run against reference model ----------------
      begin
         bit            have_instr = 1'b0;
         instr_t        cur;
         bit            busy = 1'b0;
         instr_t        pend;
         int            waited = 0;
         bit            res_known = 1'b1;
         logic          exp_ov = 1'b0;
         logic          exp_err = 1'b0;
         logic [1:0]    exp_wbc = '0;
         logic [DW-1:0] exp_res = '0;
         logic [DW-1:0] exp_rd = '0;
         int            n_done = 0;
         logic          cur_is_mem;

         do_reset();
         for (int cyc = 0; cyc < 3000; cyc++) begin
            chk("rnd_outValid", outValid, exp_ov);
            chk("rnd_memError", memError, exp_err);
            chk("rnd_memReq", bus.memReq, busy);
            chk("rnd_wbc", wbc, exp_wbc);
            chk("rnd_readData", readData, exp_rd);
            if (res_known) chk("rnd_result", result, exp_res);
            if (busy) begin
               chk("rnd_memAddr", bus.memAddr, pend.res);
               chk("rnd_memWrite", bus.memWrite, pend.mc == 2'b10);
               if (pend.mc == 2'b10) chk("rnd_memWriteData", bus.memWriteData, pend.sd);
            end
            if (exp_ov) n_done++;

            // Upstream keeps presenting an instruction until the stage takes it.
            if (!have_instr && ($urandom_range(3) != 0)) begin
               cur.mc     = 2'($urandom_range(3));
               cur.wb     = 2'($urandom_range(3));
               cur.res    = $urandom;
               cur.sd     = $urandom;
               have_instr = 1'b1;
            end
            drive(have_instr, cur.mc, cur.wb, cur.res, cur.sd);
            bus.memAck      = busy ? ($urandom_range(2) == 0) : ($urandom_range(3) == 0);
            bus.memReadData = $urandom;
            cur_is_mem      = have_instr && (cur.mc == 2'b01 || cur.mc == 2'b10);
            #1;
            chk("rnd_stall", stall, busy || cur_is_mem);

            exp_ov  = 1'b0;
            exp_err = 1'b0;
            if (!busy) begin
               if (have_instr) begin
                  if (cur_is_mem) begin
                     busy   = 1'b1;
                     pend   = cur;
                     waited = 0;
                  end else begin
                     exp_ov    = 1'b1;
                     exp_wbc   = cur.wb;
                     exp_res   = cur.res;
                     exp_rd    = '0;
                     res_known = 1'b1;
                  end
                  have_instr = 1'b0;
               end
            end else if (bus.memAck) begin
               busy      = 1'b0;
               exp_ov    = 1'b1;
               exp_wbc   = pend.wb;
               exp_res   = pend.res;
               exp_rd    = (pend.mc == 2'b01) ? bus.memReadData : '0;
               res_known = 1'b1;
            end else begin
               waited++;
`ifdef MEM_TIMEOUT_EN
               if (waited == TMO) begin
                  busy      = 1'b0;
                  exp_ov    = 1'b1;
                  exp_err   = 1'b1;
                  exp_wbc   = 2'b00;
                  exp_rd    = '0;
                  res_known = 1'b0;
               end
`endif
            end
            tick();
         end
         chk("rnd_some_completions", n_done > 100, 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
